// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel prescaler and run enable.
// Position, sync and blanking outputs are registered from the next counter state.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          en,
  output logic [CW-1:0] Qh,
  output logic [CW-1:0] Qv,
  output logic          H_Sync,
  output logic          V_Sync,
  output logic          H_ON,
  output logic          V_ON,
  output logic          video_on,
  output logic          pix_tick,
  output logic          line_end,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (CLK_DIV < 1 || (1 << CW) < H_TOTAL || (1 << CW) < V_TOTAL) begin : g_bad_cfg
      $error("vga_timing_gen: CW too small for raster or CLK_DIV < 1");
    end
  endgenerate

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [CW-1:0] hn;
  logic [CW-1:0] vn;
  logic          h_last;
  logic          v_last;
  logic          wrap_f;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          h_last_q;
  logic          fs_q;

  // Strobes are gated live by en so a freeze takes effect in the same cycle.
  assign pix_tick    = en & ~resetM & (pre == PRE_LAST);
  assign line_end    = pix_tick & h_last_q;
  assign frame_start = en & fs_q;

  always_comb begin
    pre_nxt = pre;
    if (en) begin
      pre_nxt = (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
    h_last = (Qh == H_LAST);
    v_last = (Qv == V_LAST);
    hn = Qh;
    vn = Qv;
    if (pix_tick) begin
      if (h_last) begin
        hn = '0;
        vn = v_last ? '0 : Qv + 1'b1;
      end else begin
        hn = Qh + 1'b1;
      end
    end
    wrap_f = pix_tick & h_last & v_last;
    hs_nxt = (hn >= HS_BEG) && (hn < HS_END);
    vs_nxt = (vn >= VS_BEG) && (vn < VS_END);
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      pre      <= '0;
      Qh       <= '0;
      Qv       <= '0;
      H_ON     <= 1'b1;
      V_ON     <= 1'b1;
      video_on <= 1'b1;
      H_Sync   <= ~HS_POL;
      V_Sync   <= ~VS_POL;
      h_last_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      pre      <= pre_nxt;
      Qh       <= hn;
      Qv       <= vn;
      H_ON     <= (hn < H_ACT);
      V_ON     <= (vn < V_ACT);
      video_on <= (hn < H_ACT) && (vn < V_ACT);
      H_Sync   <= hs_nxt ? HS_POL : ~HS_POL;
      V_Sync   <= vs_nxt ? VS_POL : ~VS_POL;
      h_last_q <= (hn == H_LAST);
      fs_q     <= wrap_f;
    end
  end

endmodule
